memory_sdp_clr: RTL and testbench

MEMORY_SDP_CLR -- requirements
Module: memory_sdp_clr

---
 rtl/memory_sdp_clr.sv | 145 ++++++++++++++
 tb/tb_memory_sdp_clr.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_sdp_clr.sv
// memory_sdp_clr: simple dual-port RAM (one write port, one read port) that
// zeroes itself with a one-word-per-cycle sweep after every reset.
// While the sweep runs, busy is high and user writes/reads are ignored.
// Optional build macro MEMORY_OUT_REG_EN adds an output register stage on
// dout/dout_valid (read latency 2 instead of 1).
module memory_sdp_clr #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 2,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Last address touched by the sweep, and the depth widened by one bit so
  // that out-of-range addresses can be detected for any legal depth.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;

  logic [DATA_WIDTH-1:0]   mem [0:MEM_DEPTH-1];

  logic                    wr_ok;
  logic                    rd_ok;
  logic                    bypass;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;

  // User requests only count in RUN and only for addresses inside the array.
  assign wr_ok  = (state == RUN) && wr && ({1'b0, waddr} < DEPTH);
  assign rd_ok  = (state == RUN) && re && ({1'b0, raddr} < DEPTH);
  // Same-address write and read in one cycle returns the incoming data.
  assign bypass = wr_ok && (waddr == raddr);

  // Select the single memory write port source: sweep zeroes, or user data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = din;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; clearing is done by the sweep so the
    // storage can map onto plain RAM cells instead of resettable flops.
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Sweep/run control FSM; busy is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= RUN;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          busy <= 1'b0;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Read stage: capture data on an accepted read, hold it otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= bypass ? din : mem[raddr];
      end
    end
  end

`ifdef MEMORY_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;

  // Extra output pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= rd_data;
      dout_valid_q <= rd_valid;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`else
  assign dout       = rd_data;
  assign dout_valid = rd_valid;
`endif

endmodule

// File: tb/tb_memory_sdp_clr.sv
// Directed testbench for memory_sdp_clr. Two instances: default geometry
// (depth 4) and a depth-3 instance for out-of-range address handling.
module tb_memory_sdp_clr;

`ifdef MEMORY_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;

  logic       wr, re;
  logic [1:0] waddr, raddr, din;
  logic [1:0] dout;
  logic       dout_valid, busy;

  logic       wr3, re3;
  logic [1:0] waddr3, raddr3, din3;
  logic [1:0] dout3;
  logic       dout_valid3, busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_sdp_clr dut (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  memory_sdp_clr #(.DATA_WIDTH(2), .ADDR_WIDTH(2), .MEM_DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .wr(wr3), .waddr(waddr3), .din(din3),
    .re(re3), .raddr(raddr3), .dout(dout3), .dout_valid(dout_valid3), .busy(busy3)
  );

  // ---------------- stimulus helpers (drive/capture only) ----------------
  task automatic write_word(input logic [1:0] a, input logic [1:0] d);
    @(negedge clk); wr = 1'b1; waddr = a; din = d;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic read_word(input logic [1:0] a, output logic [1:0] d,
                           output logic v, output logic v_after);
    @(negedge clk); re = 1'b1; raddr = a;
    @(negedge clk); re = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    d = dout; v = dout_valid;
    @(negedge clk);
    v_after = dout_valid;
  endtask

  task automatic write_word3(input logic [1:0] a, input logic [1:0] d);
    @(negedge clk); wr3 = 1'b1; waddr3 = a; din3 = d;
    @(negedge clk); wr3 = 1'b0;
  endtask

  task automatic read_word3(input logic [1:0] a, output logic [1:0] d,
                            output logic v, output logic v_after);
    @(negedge clk); re3 = 1'b1; raddr3 = a;
    @(negedge clk); re3 = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    d = dout3; v = dout_valid3;
    @(negedge clk);
    v_after = dout_valid3;
  endtask

  // Counts clock edges spent with busy high on each instance (bounded).
  task automatic count_busy(output int n, output int n3);
    n = 0; n3 = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy)  n++;
      if (busy3) n3++;
      if (!busy && !busy3) break;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int n, n3;
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (dout !== 2'b00 || dout_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: dout=%b valid=%b busy=%b, want 00 0 1", dout, dout_valid, busy);
    end
    checks++;
    if (dout3 !== 2'b00 || dout_valid3 !== 1'b0 || busy3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs3: dout=%b valid=%b busy=%b, want 00 0 1", dout3, dout_valid3, busy3);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    count_busy(n, n3);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL sweep_cycles: busy cycles=%0d, want 4", n);
    end
    checks++;
    if (n3 !== 3) begin
      errors++;
      $display("FAIL sweep_cycles_depth3: busy cycles=%0d, want 3", n3);
    end
  endtask

  task automatic test_sweep_zero;
    logic [1:0] d; logic v, va;
    for (int a = 0; a < 4; a++) begin
      read_word(2'(a), d, v, va);
      checks++;
      if (d !== 2'b00 || v !== 1'b1 || va !== 1'b0) begin
        errors++;
        $display("FAIL sweep_zero[%0d]: dout=%b valid=%b next_valid=%b, want 00 1 0", a, d, v, va);
      end
    end
  endtask

  task automatic test_write_read;
    logic [1:0] d; logic v, va;
    write_word(2'd1, 2'b10);
    read_word(2'd1, d, v, va);
    checks++;
    if (d !== 2'b10 || v !== 1'b1 || va !== 1'b0) begin
      errors++;
      $display("FAIL write_read: dout=%b valid=%b next_valid=%b, want 10 1 0", d, v, va);
    end
    @(negedge clk);
    checks++;
    if (dout !== 2'b10 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL dout_hold: dout=%b valid=%b, want 10 0", dout, dout_valid);
    end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    wr = 1'b1; waddr = 2'd2; din = 2'b11;
    re = 1'b1; raddr = 2'd2;
    @(negedge clk); wr = 1'b0; re = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (dout !== 2'b11 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL bypass: dout=%b valid=%b, want 11 1", dout, dout_valid);
    end
  endtask

  task automatic test_parallel;
    logic [1:0] d; logic v, va;
    @(negedge clk);
    wr = 1'b1; waddr = 2'd0; din = 2'b01;
    re = 1'b1; raddr = 2'd1;
    @(negedge clk); wr = 1'b0; re = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (dout !== 2'b10 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL parallel_read: dout=%b valid=%b, want 10 1", dout, dout_valid);
    end
    read_word(2'd0, d, v, va);
    checks++;
    if (d !== 2'b01 || v !== 1'b1) begin
      errors++;
      $display("FAIL parallel_write: dout=%b valid=%b, want 01 1", d, v);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_data [4];
    exp_data[0] = 2'b01; exp_data[1] = 2'b10; exp_data[2] = 2'b11; exp_data[3] = 2'b00;
    for (int j = 0; j <= 4 + LAT; j++) begin
      @(negedge clk);
      checks++;
      if (j - LAT >= 0 && j - LAT <= 3) begin
        if (dout !== exp_data[j-LAT] || dout_valid !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back[%0d]: dout=%b valid=%b, want %b 1", j - LAT, dout, dout_valid, exp_data[j-LAT]);
        end
      end else if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back_idle[%0d]: valid=%b, want 0", j, dout_valid);
      end
      if (j < 4) begin
        re = 1'b1; raddr = 2'(j);
      end else begin
        re = 1'b0;
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [1:0] d; logic v, va;
    write_word3(2'd2, 2'b11);
    read_word3(2'd2, d, v, va);
    checks++;
    if (d !== 2'b11 || v !== 1'b1) begin
      errors++;
      $display("FAIL depth3_read2: dout=%b valid=%b, want 11 1", d, v);
    end
    @(negedge clk);
    wr3 = 1'b1; waddr3 = 2'd3; din3 = 2'b01;
    re3 = 1'b1; raddr3 = 2'd3;
    @(negedge clk); wr3 = 1'b0; re3 = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      checks++;
      if (dout3 !== 2'b11 || dout_valid3 !== 1'b0) begin
        errors++;
        $display("FAIL out_of_range[%0d]: dout=%b valid=%b, want 11 0", k, dout3, dout_valid3);
      end
      @(negedge clk);
    end
    read_word3(2'd0, d, v, va);
    checks++;
    if (d !== 2'b00 || v !== 1'b1) begin
      errors++;
      $display("FAIL depth3_read0: dout=%b valid=%b, want 00 1", d, v);
    end
  endtask

  task automatic test_busy_ignore;
    logic [1:0] d; logic v, va;
    int m;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wr = 1'b1; waddr = 2'd1; din = 2'b11;
    re = 1'b1; raddr = 2'd1;
    m = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0 || dout !== 2'b00) begin
        errors++;
        $display("FAIL busy_ignore[%0d]: dout=%b valid=%b, want 00 0", k, dout, dout_valid);
      end
      if (!busy) begin
        m = k;
        break;
      end
    end
    wr = 1'b0; re = 1'b0;
    checks++;
    if (m !== 4) begin
      errors++;
      $display("FAIL busy_ignore_sweep: busy cycles=%0d, want 4", m);
    end
    for (int a = 0; a < 4; a++) begin
      read_word(2'(a), d, v, va);
      checks++;
      if (d !== 2'b00 || v !== 1'b1) begin
        errors++;
        $display("FAIL busy_ignore_zero[%0d]: dout=%b valid=%b, want 00 1", a, d, v);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    logic [1:0] d; logic v, va;
    int n, n3;
    write_word(2'd3, 2'b01);
    read_word(2'd3, d, v, va);
    checks++;
    if (d !== 2'b01 || v !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: dout=%b valid=%b, want 01 1", d, v);
    end
    // Reset right after a read is accepted: the pending result is dropped.
    @(negedge clk); re = 1'b1; raddr = 2'd3;
    @(posedge clk); #1; rst = 1'b1; re = 1'b0;
    #1;
    checks++;
    if (dout !== 2'b00 || dout_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_reset: dout=%b valid=%b busy=%b, want 00 0 1", dout, dout_valid, busy);
    end
    @(negedge clk); rst = 1'b0;
    // Two sweep writes (addresses 0 and 1), then reset with clr_cnt at 2.
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    count_busy(n, n3);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL restart_sweep: busy cycles=%0d, want 4", n);
    end
    read_word(2'd3, d, v, va);
    checks++;
    if (d !== 2'b00 || v !== 1'b1) begin
      errors++;
      $display("FAIL restart_clears: dout=%b valid=%b, want 00 1", d, v);
    end
  endtask

  initial begin
    rst = 1'b0;
    wr = 1'b0; re = 1'b0; waddr = '0; raddr = '0; din = '0;
    wr3 = 1'b0; re3 = 1'b0; waddr3 = '0; raddr3 = '0; din3 = '0;
    test_reset();
    test_sweep_zero();
    test_write_read();
    test_bypass();
    test_parallel();
    test_back_to_back();
    test_out_of_range();
    test_busy_ignore();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
